alu_op_sequencer: RTL and testbench

Front-end controller for the 8-bit ALU and flags register. It accepts one ALU operation at a time over a valid/ready handshake. Single-cycle ops are computed in one registered step; shifts and rotates are iterated one bit per cycle. It then drives the flags register's `alu_result`, `carry_in`, `overflow_in` and `update_flags` inputs, and returns the result to the execute stage. It sits between the decode/execute stage and `flags_register`, and is the only block allowed to pulse `update_flags`.

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/alu_shift_step.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU operation sequencer.
// Opcode encoding matches the decode stage; codes D..F are reserved NOPs.
package alu_seq_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_ADC   = 4'h1,
    OP_SUB   = 4'h2,
    OP_SBB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_CMP   = 4'h7,
    OP_SHL   = 4'h8,
    OP_SHR   = 4'h9,
    OP_SAR   = 4'hA,
    OP_ROL   = 4'hB,
    OP_ROR   = 4'hC,
    OP_NOP_D = 4'hD,
    OP_NOP_E = 4'hE,
    OP_NOP_F = 4'hF
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate of a WIDTH-bit value; reports the bit that left the word.
module alu_shift_step
  import alu_seq_pkg::*;
(
  input  alu_op_t           op,
  input  logic [WIDTH-1:0]  value,
  output logic [WIDTH-1:0]  next_value,
  output logic              shifted_bit
);

  always_comb begin
    next_value  = value;
    shifted_bit = 1'b0;
    case (op)
      OP_SHL: begin
        next_value  = {value[WIDTH-2:0], 1'b0};
        shifted_bit = value[WIDTH-1];
      end
      OP_SHR: begin
        next_value  = {1'b0, value[WIDTH-1:1]};
        shifted_bit = value[0];
      end
      OP_SAR: begin
        next_value  = {value[WIDTH-1], value[WIDTH-1:1]};
        shifted_bit = value[0];
      end
      OP_ROL: begin
        next_value  = {value[WIDTH-2:0], value[WIDTH-1]};
        shifted_bit = value[WIDTH-1];
      end
      OP_ROR: begin
        next_value  = {value[0], value[WIDTH-1:1]};
        shifted_bit = value[0];
      end
      default: begin
        next_value  = value;
        shifted_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one ALU op at a time, computes it (iterating shifts bit by bit),
// and presents the result plus CF/OF and a one-cycle update_flags strobe.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic              carry_flag,
  output logic              res_valid,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_write,
  output logic [WIDTH-1:0]  alu_result,
  output logic              carry_out,
  output logic              overflow_out,
  output logic              update_flags,
  output logic              busy
);

  localparam int MSB = WIDTH - 1;

  seq_state_t        state_reg;
  alu_op_t           op_reg;
  logic [WIDTH-1:0]  val_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              msb_reg;
  logic              one_reg;
  logic [WIDTH-1:0]  res_data_reg;
  logic              cf_reg;
  logic              of_reg;
  logic              res_valid_reg;
  logic              res_write_reg;
  logic              upd_reg;

  alu_op_t           op_in;
  logic [CNT_W-1:0]  cnt_in;
  logic              shift_req;
  logic [WIDTH:0]    sum9;
  logic [WIDTH-1:0]  comb_res;
  logic              comb_cf;
  logic              comb_of;
  logic              comb_write;
  logic              comb_upd;
  logic [WIDTH-1:0]  step_val;
  logic              step_bit;
  logic              shift_of;

  assign op_in     = alu_op_t'(op_code);
  assign cnt_in    = op_b[CNT_W-1:0];
  assign shift_req = is_shift(op_in) && (cnt_in != '0);

  // Single-cycle result, evaluated on the operands present at accept.
  always_comb begin
    sum9       = '0;
    comb_res   = op_a;
    comb_cf    = 1'b0;
    comb_of    = 1'b0;
    comb_write = 1'b1;
    comb_upd   = 1'b1;
    case (op_in)
      OP_ADD, OP_ADC: begin
        sum9     = {1'b0, op_a} + {1'b0, op_b}
                 + {{WIDTH{1'b0}}, (op_in == OP_ADC) & carry_flag};
        comb_res = sum9[WIDTH-1:0];
        comb_cf  = sum9[WIDTH];
        comb_of  = (op_a[MSB] == op_b[MSB]) && (sum9[MSB] != op_a[MSB]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        sum9       = {1'b0, op_a} - {1'b0, op_b}
                   - {{WIDTH{1'b0}}, (op_in == OP_SBB) & carry_flag};
        comb_res   = sum9[WIDTH-1:0];
        comb_cf    = sum9[WIDTH];
        comb_of    = (op_a[MSB] != op_b[MSB]) && (sum9[MSB] != op_a[MSB]);
        comb_write = (op_in != OP_CMP);
      end
      OP_AND: comb_res = op_a & op_b;
      OP_OR:  comb_res = op_a | op_b;
      OP_XOR: comb_res = op_a ^ op_b;
      OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
        // Only reached with a zero count: pass op_a through, leave flags alone.
        comb_res = op_a;
        comb_upd = 1'b0;
      end
      default: begin
        comb_write = 1'b0;
        comb_upd   = 1'b0;
      end
    endcase
  end

  alu_shift_step u_shift_step (
    .op          (op_reg),
    .value       (val_reg),
    .next_value  (step_val),
    .shifted_bit (step_bit)
  );

  // OF is defined only for single-bit shifts; multi-bit shifts clear it.
  always_comb begin
    shift_of = 1'b0;
    if (one_reg) begin
      case (op_reg)
        OP_SHL, OP_ROL: shift_of = step_val[MSB] ^ step_bit;
        OP_SHR:         shift_of = msb_reg;
        OP_ROR:         shift_of = step_val[MSB] ^ step_val[MSB-1];
        default:        shift_of = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= OP_ADD;
      val_reg       <= '0;
      cnt_reg       <= '0;
      msb_reg       <= 1'b0;
      one_reg       <= 1'b0;
      res_data_reg  <= '0;
      cf_reg        <= 1'b0;
      of_reg        <= 1'b0;
      res_valid_reg <= 1'b0;
      res_write_reg <= 1'b0;
      upd_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (op_valid) begin
            op_reg        <= op_in;
            val_reg       <= op_a;
            cnt_reg       <= cnt_in;
            msb_reg       <= op_a[MSB];
            one_reg       <= (cnt_in == CNT_W'(1));
            res_write_reg <= comb_write;
            if (shift_req) begin
              state_reg <= SHIFT;
            end else begin
              state_reg     <= DONE;
              res_valid_reg <= 1'b1;
              upd_reg       <= comb_upd;
              res_data_reg  <= comb_res;
              if (comb_upd) begin
                cf_reg <= comb_cf;
                of_reg <= comb_of;
              end
            end
          end
        end
        SHIFT: begin
          val_reg <= step_val;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_reg     <= DONE;
            res_valid_reg <= 1'b1;
            upd_reg       <= 1'b1;
            res_data_reg  <= step_val;
            cf_reg        <= step_bit;
            of_reg        <= shift_of;
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          res_valid_reg <= 1'b0;
          res_write_reg <= 1'b0;
          upd_reg       <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign op_ready     = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign res_valid    = res_valid_reg;
  assign res_data     = res_data_reg;
  assign res_write    = res_write_reg;
  assign alu_result   = res_data_reg;
  assign carry_out    = cf_reg;
  assign overflow_out = of_reg;
  assign update_flags = upd_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: the driver queues hand-computed results, a negedge monitor
// checks each res_valid pulse; a small flags model closes the carry loop.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op_code = 4'h0;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic       carry_flag;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_write;
  logic [7:0] alu_result;
  logic       carry_out;
  logic       overflow_out;
  logic       update_flags;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] data;
    logic       cf;
    logic       of_;
    logic       w;
    logic       u;
    logic       chk_data;
    logic       chk_flags;
    int         cyc;
  } exp_t;

  exp_t q[$];

  // Flags register model: captures on the edge that ends DONE.
  logic fl_zf, fl_sf, fl_pf, fl_cf, fl_of;
  assign carry_flag = fl_cf;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      {fl_zf, fl_sf, fl_pf, fl_cf, fl_of} <= 5'b0;
    end else if (update_flags) begin
      fl_zf <= (alu_result == 8'h00);
      fl_sf <= alu_result[7];
      fl_pf <= ~^alu_result;
      fl_cf <= carry_out;
      fl_of <= overflow_out;
    end
  end

  alu_op_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .op_a         (op_a),
    .op_b         (op_b),
    .carry_flag   (carry_flag),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_write    (res_write),
    .alu_result   (alu_result),
    .carry_out    (carry_out),
    .overflow_out (overflow_out),
    .update_flags (update_flags),
    .busy         (busy)
  );

  // Monitor: every res_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && update_flags) begin
      checks++;
      if (!res_valid) begin
        errors++;
        $display("FAIL upd_without_valid res_valid=%b required=1 cyc=%0d", res_valid, cyc);
      end
    end
    if (!rst && res_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_res_valid data=%h cyc=%0d required=no result", res_data, cyc);
      end else begin
        exp_t e;
        logic ok;
        e  = q.pop_front();
        ok = (cyc == e.cyc) && (res_write == e.w) && (update_flags == e.u);
        if (e.chk_data)  ok = ok && (res_data == e.data) && (alu_result == e.data);
        if (e.chk_flags) ok = ok && (carry_out == e.cf) && (overflow_out == e.of_);
        if (!ok) begin
          errors++;
          $display("FAIL txn op=%h got cyc=%0d data=%h res=%h cf=%b of=%b w=%b u=%b required cyc=%0d data=%h cf=%b of=%b w=%b u=%b",
                   e.op, cyc, res_data, alu_result, carry_out, overflow_out, res_write, update_flags,
                   e.cyc, e.data, e.cf, e.of_, e.w, e.u);
        end else begin
          $display("txn op=%h data=%h cf=%b of=%b w=%b u=%b cyc=%0d ok",
                   e.op, res_data, carry_out, overflow_out, res_write, update_flags, cyc);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic ecf, input logic eof,
                       input logic ew, input logic eu, input logic cd, input logic cfl,
                       input int lat, input logic expect_res, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    while (!op_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!op_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%h op_ready=%b required=1", op, op_ready);
      op_valid = 1'b0;
      return;
    end
    if (expect_res) begin
      e.op = op; e.data = ed; e.cf = ecf; e.of_ = eof; e.w = ew; e.u = eu;
      e.chk_data = cd; e.chk_flags = cfl; e.cyc = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic check_flags(input string name, input logic [4:0] req);
    checks++;
    if ({fl_zf, fl_sf, fl_pf, fl_cf, fl_of} !== req) begin
      errors++;
      $display("FAIL %s zf/sf/pf/cf/of=%b required=%b", name, {fl_zf, fl_sf, fl_pf, fl_cf, fl_of}, req);
    end else begin
      $display("flags %s zf/sf/pf/cf/of=%b ok", name, req);
    end
  endtask

  task automatic check_idle(input string name);
    logic [22:0] got;
    logic [22:0] req;
    got = {op_ready, busy, res_valid, update_flags, res_write, res_data, alu_result, carry_out, overflow_out};
    req = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s outputs=%h required=%h", name, got, req);
    end else begin
      $display("idle %s outputs=%h ok", name, got);
    end
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset_state");

    //     op     a      b      data   cf    of    w     u     cd    cfl   lat
    issue(4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, w);
    @(negedge clk);
    @(negedge clk);
    check_flags("add_7f_01", 5'b01001);
    issue(4'h2, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, w);
    issue(4'h1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL throughput wait=%0d required=1", w);
    end
    issue(4'h0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, w);
    issue(4'h3, 8'h10, 8'h01, 8'h0E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, w);
    issue(4'h2, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, w);
    issue(4'h4, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, w);
    issue(4'h5, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, w);
    issue(4'h6, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, w);
    issue(4'h7, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b1, w);
    @(negedge clk);
    @(negedge clk);
    check_flags("cmp_05_05", 5'b10100);

    issue(4'h8, 8'h81, 8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, w);
    issue(4'h9, 8'h80, 8'hF7, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8, 1'b1, w);
    issue(4'h0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, w);
    checks++;
    if (w != 8) begin
      errors++;
      $display("FAIL held_while_busy wait=%0d required=8", w);
    end else begin
      $display("held_while_busy wait=%0d ok", w);
    end
    issue(4'hB, 8'h80, 8'h01, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, w);
    issue(4'hC, 8'h01, 8'h01, 8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, w);
    issue(4'hA, 8'h81, 8'h02, 8'hE0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1, w);
    issue(4'hA, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1, w);
    issue(4'h8, 8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1, w);
    issue(4'hE, 8'h33, 8'h44, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, w);

    // ROR by 3 aborted by reset two cycles after accept.
    issue(4'hC, 8'h01, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, w);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("abort_reset");
    repeat (6) @(negedge clk);
    check_idle("abort_quiet");

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
